// File: rtl/chart_sequencer.sv
// -----------------------------------------------------------------------------
// chart_sequencer
//
// Plays back the note chart of the selected song. Each chart entry is a 16-bit
// ROM word {delta[11:0], lane_mask[3:0]}; delta is the number of chart ticks
// after the previous entry's target time. When the song clock reaches an
// entry's absolute target time, the lane mask is emitted as a one-cycle spawn
// pulse. A word of all zeros ends the chart. The block also owns the song
// clock: a TICK_DIV clock divider that advances song_time.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   music_id   song select, sampled only when a start is accepted
//   start      one-cycle pulse, begins playback from IDLE or DONE
//   pause      level, freezes the song clock and holds emission while high
//   stop       one-cycle pulse, aborts to IDLE (wins over start)
//   rom_addr   chart ROM address {song, entry index}
//   rom_data   chart ROM word, valid one cycle after rom_addr
//   spawn      one-cycle per-lane spawn pulse
//   playing    high while a song is being played (FETCH/LOAD/WAIT/EMIT)
//   done       high once the chart has finished (DONE)
//   song_time  chart ticks elapsed since the accepted start (saturating)
// -----------------------------------------------------------------------------
module chart_sequencer #(
    parameter int TICK_DIV = 500000,
    parameter int IDX_W    = 10,
    parameter int TIME_W   = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          music_id,
    input  logic                start,
    input  logic                pause,
    input  logic                stop,
    output logic [IDX_W+1:0]    rom_addr,
    input  logic [15:0]         rom_data,
    output logic [3:0]          spawn,
    output logic                playing,
    output logic                done,
    output logic [TIME_W-1:0]   song_time
);

    localparam int DIV_W = $clog2(TICK_DIV);
    // The target adder must be wide enough for both the 12-bit delta and the
    // target register, plus a carry bit to detect saturation.
    localparam int SUM_W = ((TIME_W > 12) ? TIME_W : 12) + 1;
    localparam logic [SUM_W-1:0] TIME_MAX = SUM_W'((64'd1 << TIME_W) - 64'd1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          song_q_reg, song_q_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [TIME_W-1:0]   target_reg, target_next;
    logic [3:0]          mask_reg, mask_next;
    logic [3:0]          spawn_reg, spawn_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [TIME_W-1:0]   song_time_reg, song_time_next;

    logic                run_clock;
    logic                tick;
    logic [SUM_W-1:0]    target_sum;
    logic [TIME_W-1:0]   target_sat;

    assign playing   = (state_reg == ST_FETCH) || (state_reg == ST_LOAD) ||
                       (state_reg == ST_WAIT)  || (state_reg == ST_EMIT);
    assign done      = (state_reg == ST_DONE);
    assign spawn     = spawn_reg;
    assign song_time = song_time_reg;
    assign rom_addr  = {song_q_reg, idx_reg};

    // The song clock only runs while a song is playing and not paused.
    assign run_clock = playing && !pause;
    assign tick      = run_clock && (div_reg == DIV_LAST);

    // Absolute target time: each delta is added to the previous target, so
    // the cycles spent fetching never shift the chart timing.
    assign target_sum = SUM_W'(target_reg) + SUM_W'(rom_data[15:4]);
    assign target_sat = (target_sum > TIME_MAX) ? {TIME_W{1'b1}}
                                                : target_sum[TIME_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            song_q_reg    <= '0;
            idx_reg       <= '0;
            target_reg    <= '0;
            mask_reg      <= '0;
            spawn_reg     <= '0;
            div_reg       <= '0;
            song_time_reg <= '0;
        end else begin
            song_q_reg    <= song_q_next;
            idx_reg       <= idx_next;
            target_reg    <= target_next;
            mask_reg      <= mask_next;
            spawn_reg     <= spawn_next;
            div_reg       <= div_next;
            song_time_reg <= song_time_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        song_q_next    = song_q_reg;
        idx_next       = idx_reg;
        target_next    = target_reg;
        mask_next      = mask_reg;
        spawn_next     = '0;
        div_next       = div_reg;
        song_time_next = song_time_reg;

        if (run_clock) begin
            if (tick) begin
                div_next = '0;
                if (song_time_reg != {TIME_W{1'b1}}) begin
                    song_time_next = song_time_reg + TIME_W'(1);
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end

        unique case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    state_next     = ST_FETCH;
                    song_q_next    = music_id;
                    idx_next       = '0;
                    target_next    = '0;
                    div_next       = '0;
                    song_time_next = '0;
                end
            end
            ST_FETCH: begin
                // rom_addr is on the bus this cycle; the word arrives in LOAD.
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (rom_data == 16'h0000) begin
                    state_next = ST_DONE;
                end else begin
                    target_next = target_sat;
                    mask_next   = rom_data[3:0];
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((song_time_reg >= target_reg) && !pause) begin
                    spawn_next = mask_reg;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // The last index ends the song instead of wrapping to entry 0.
                if (idx_reg == {IDX_W{1'b1}}) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (stop) begin
            state_next = ST_IDLE;
            spawn_next = '0;
        end
    end

endmodule

// File: tb/tb_chart_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chart_sequencer
//
// Drives chart_sequencer with TICK_DIV=4, IDX_W=4, TIME_W=6 against a chart
// ROM kept in the bench. Expected behaviour is computed per song run from the
// chart contents and the pause schedule: song_time is the count of unpaused
// playing cycles divided by TICK_DIV, and each entry fires one cycle after the
// first WAIT cycle in which song_time has reached its absolute target.
// -----------------------------------------------------------------------------
module tb_chart_sequencer;

    localparam int TICK_DIV = 4;
    localparam int IDX_W    = 4;
    localparam int TIME_W   = 6;
    localparam int TMAX     = 63;
    localparam int NMAX     = 1024;

    logic                clk;
    logic                rst;
    logic [1:0]          music_id;
    logic                start;
    logic                pause;
    logic                stop;
    logic [IDX_W+1:0]    rom_addr;
    logic [15:0]         rom_data;
    logic [3:0]          spawn;
    logic                playing;
    logic                done;
    logic [TIME_W-1:0]   song_time;

    chart_sequencer #(
        .TICK_DIV (TICK_DIV),
        .IDX_W    (IDX_W),
        .TIME_W   (TIME_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .music_id  (music_id),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .spawn     (spawn),
        .playing   (playing),
        .done      (done),
        .song_time (song_time)
    );

    logic [15:0] rom_mem [0:63];

    // Registered chart ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Per-run expectation, indexed by cycle relative to the accepted start
    // (cycle 0 is the first cycle after the start edge).
    bit          pz        [0:NMAX-1];
    int          act       [0:NMAX];
    logic [3:0]  exp_spawn [0:NMAX-1];
    int          end_c;
    bit          ends_done;
    int          end_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat_time(input int a);
        return (a / TICK_DIV > TMAX) ? TMAX : a / TICK_DIV;
    endfunction

    task automatic predict(input int song, input int stop_r);
        int t, tgt, w, i;
        bit fin;
        logic [15:0] word;
        act[0] = 0;
        for (int r = 0; r < NMAX; r++) begin
            act[r+1]     = act[r] + (pz[r] ? 0 : 1);
            exp_spawn[r] = 4'h0;
        end
        t = 0; tgt = 0; i = 0; fin = 1'b0;
        end_c = NMAX - 8; ends_done = 1'b1; end_idx = 0;
        while (!fin) begin
            word = rom_mem[song*16 + i];
            if (word == 16'h0000) begin
                end_c = t + 2; end_idx = i; fin = 1'b1;
            end else begin
                tgt = tgt + int'(word[15:4]);
                if (tgt > TMAX) tgt = TMAX;
                w = t + 2;
                while (w < NMAX - 16 && !(sat_time(act[w]) >= tgt && !pz[w])) w++;
                exp_spawn[w+1] = word[3:0];
                if (i == 15 || w >= NMAX - 16) begin
                    end_c = w + 2; end_idx = i; fin = 1'b1;
                end else begin
                    t = w + 2; i++;
                end
            end
        end
        if (stop_r >= 0 && stop_r + 1 < end_c) begin
            end_c = stop_r + 1;
            ends_done = 1'b0;
            for (int r = end_c; r < NMAX; r++) exp_spawn[r] = 4'h0;
        end
    endtask

    // Called at #1 after a clock edge with the DUT in IDLE or DONE.
    task automatic run_song(input int song, input int pprob, input int pw_lo, input int pw_hi,
                            input int stop_r, input bit noise, output int last_spawn);
        int ts;
        for (int r = 0; r < NMAX; r++)
            pz[r] = (r >= pw_lo && r <= pw_hi) || ($urandom_range(0, 99) < pprob);
        predict(song, stop_r);
        last_spawn = -1;
        start = 1'b1; stop = 1'b0; pause = 1'b0; music_id = 2'(song);
        for (int r = 0; r <= end_c + 3; r++) begin
            @(posedge clk); #1;
            ts = sat_time(act[(r < end_c) ? r : end_c]);
            check($sformatf("s%0d spawn@%0d", song, r), 32'(spawn), 32'(exp_spawn[r]));
            check($sformatf("s%0d playing@%0d", song, r), 32'(playing), 32'(r < end_c));
            check($sformatf("s%0d done@%0d", song, r), 32'(done), 32'(r >= end_c && ends_done));
            check($sformatf("s%0d song_time@%0d", song, r), 32'(song_time), 32'(ts));
            if (r == end_c && ends_done)
                check($sformatf("s%0d rom_addr_end", song), 32'(rom_addr), 32'(song*16 + end_idx));
            if (spawn != 4'h0) last_spawn = r;
            start    = 1'b0;
            stop     = (r == stop_r);
            pause    = pz[r];
            music_id = noise ? 2'($urandom_range(0, 3)) : 2'(song);
            if (noise && r < end_c - 1 && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    initial begin
        int last_a, last_b, dummy;
        logic [11:0] d;
        logic [3:0]  m;

        vectors = 0; miscompares = 0;
        rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; music_id = 2'd0;

        for (int a = 0; a < 64; a++) rom_mem[a] = 16'h0000;
        // Song 0: six random entries then end marker.
        for (int e = 0; e < 6; e++) begin
            d = 12'($urandom_range(0, 3));
            m = 4'($urandom_range(0, 15));
            if (d == 0 && m == 0) m = 4'h1;
            rom_mem[e] = {d, m};
        end
        // Song 1: delta0 lane0, delta2 lanes 1+3, end.
        rom_mem[16] = 16'h0001;
        rom_mem[17] = 16'h002A;
        // Song 2: sixteen non-end entries, no end marker inside the song.
        for (int e = 0; e < 16; e++) begin
            d = 12'($urandom_range(0, 2));
            m = 4'($urandom_range(0, 15));
            if (d == 0 && m == 0) m = 4'h8;
            rom_mem[32+e] = {d, m};
        end
        // Song 3: rest, chord, target that saturates at the song_time limit, end.
        rom_mem[48] = 16'h0030;
        rom_mem[49] = 16'h000F;
        rom_mem[50] = 16'h0645;

        #1;
        check("rst spawn", 32'(spawn), 32'h0);
        check("rst playing", 32'(playing), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst song_time", 32'(song_time), 32'h0);
        check("rst rom_addr", 32'(rom_addr), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_song(1, 0, -1, -1, -1, 1'b0, last_a);
        check("song1 last spawn", 32'(last_a), 32'd9);

        run_song(1, 0, 5, 24, -1, 1'b0, last_b);
        check("pause shift", 32'(last_b), 32'd29);

        run_song(2, 25, -1, -1, -1, 1'b1, dummy);

        // Stop together with start from DONE must land in IDLE.
        start = 1'b1; stop = 1'b1; music_id = 2'd3;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        check("stop+start playing", 32'(playing), 32'h0);
        check("stop+start done", 32'(done), 32'h0);
        @(posedge clk); #1;
        check("stop+start spawn", 32'(spawn), 32'h0);
        check("stop+start idle", 32'(playing), 32'h0);

        run_song(3, 0, -1, -1, -1, 1'b0, dummy);

        for (int k = 0; k < 3; k++) run_song(0, 30, -1, -1, -1, 1'b1, dummy);

        // Stop during WAIT of entry 1: no second spawn, idx held at 1.
        run_song(1, 0, -1, -1, 7, 1'b0, last_a);
        check("stop last spawn", 32'(last_a), 32'd3);
        check("stop rom_addr", 32'(rom_addr), 32'(16 + 1));

        // Asynchronous reset in the middle of an EMIT cycle.
        start = 1'b1; music_id = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10 && spawn == 4'h0; k++) begin
            @(posedge clk); #1;
        end
        check("pre-rst spawn", 32'(spawn), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async rst spawn", 32'(spawn), 32'h0);
        check("async rst playing", 32'(playing), 32'h0);
        check("async rst song_time", 32'(song_time), 32'h0);
        check("async rst rom_addr", 32'(rom_addr), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-rst idle spawn", 32'(spawn), 32'h0);
        run_song(1, 0, -1, -1, -1, 1'b0, last_a);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
